// File: rtl/debug_regfile_ctrl_if.sv
// Debug access channel between a debug requester and the GPR debug controller.
// One request/response pair at a time, valid/ready handshake on each direction.
interface debug_regfile_ctrl_if;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_write;
  logic [4:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [31:0] dbg_rsp_rdata;
  logic        dbg_rsp_err;

  modport master (
    output dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata, dbg_rsp_ready,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err
  );

  modport slave (
    input  dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata, dbg_rsp_ready,
    output dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err
  );
endinterface

// File: rtl/debug_regfile_ctrl.sv
// Debug GPR access controller: halts the core, waits for the pipeline to drain,
// performs one regfile access through the debug port and returns a response.
module debug_regfile_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  debug_regfile_ctrl_if.slave  dbg,
  input  logic                 dbg_hold,
  output logic                 halt_req,
  input  logic                 pipe_empty,
  output logic                 rf_dbg_en,
  output logic                 rf_dbg_we,
  output logic [4:0]           rf_dbg_addr,
  output logic [31:0]          rf_dbg_wdata,
  input  logic [31:0]          rf_dbg_rdata,
  output logic                 halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ACCESS,
    S_RESP,
    S_RESUME
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(DRAIN_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        halt_q, halt_d;
  logic        ready_q, ready_d;
  logic        accept;

  assign accept = ready_q & dbg.dbg_req_valid;

  // State register. Ready is a flop (not a state decode) so it stays low
  // while reset is held even though the FSM rests in IDLE.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and captured-data logic.
  // NOTE: every variable gets a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    halt_d  = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        halt_d = dbg_hold;
        if (accept) begin
          write_d = dbg.dbg_req_write;
          addr_d  = dbg.dbg_req_addr;
          wdata_d = dbg.dbg_req_wdata;
          cnt_d   = '0;
          halt_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        // An empty pipe wins over a timeout landing in the same cycle.
        if (pipe_empty) begin
          state_d = S_ACCESS;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_ACCESS: begin
        rdata_d = (!write_q && (addr_q != 5'd0)) ? rf_dbg_rdata : 32'd0;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (dbg.dbg_rsp_ready) state_d = S_RESUME;
      end
      S_RESUME: begin
        halt_d  = dbg_hold;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Outputs: registered or decoded from state; only halted sees pipe_empty.
  always_comb begin
    dbg.dbg_req_ready = ready_q;
    dbg.dbg_rsp_valid = (state_q == S_RESP);
    dbg.dbg_rsp_rdata = rdata_q;
    dbg.dbg_rsp_err   = err_q;
    halt_req          = halt_q;
    halted            = halt_q & pipe_empty;
    rf_dbg_en         = 1'b0;
    rf_dbg_we         = 1'b0;
    rf_dbg_addr       = '0;
    rf_dbg_wdata      = '0;
    if (state_q == S_ACCESS) begin
      rf_dbg_en    = 1'b1;
      rf_dbg_we    = write_q && (addr_q != 5'd0);
      rf_dbg_addr  = addr_q;
      rf_dbg_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_debug_regfile_ctrl.sv
// Directed bench for debug_regfile_ctrl: expected responses are queued at issue
// time and popped by a monitor on every response handshake.
module tb_debug_regfile_ctrl;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  debug_regfile_ctrl_if dbg_if ();

  logic        dbg_hold = 1'b0;
  logic        pipe_empty = 1'b0;
  logic        halt_req, rf_dbg_en, rf_dbg_we, halted;
  logic [4:0]  rf_dbg_addr;
  logic [31:0] rf_dbg_wdata, rf_dbg_rdata;
  logic [31:0] rf [32];

  assign rf_dbg_rdata = rf[rf_dbg_addr];

  debug_regfile_ctrl #(.DRAIN_TIMEOUT(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .dbg          (dbg_if.slave),
    .dbg_hold     (dbg_hold),
    .halt_req     (halt_req),
    .pipe_empty   (pipe_empty),
    .rf_dbg_en    (rf_dbg_en),
    .rf_dbg_we    (rf_dbg_we),
    .rf_dbg_addr  (rf_dbg_addr),
    .rf_dbg_wdata (rf_dbg_wdata),
    .rf_dbg_rdata (rf_dbg_rdata),
    .halted       (halted)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  int          we_cnt = 0;
  int          halt_drops = 0;
  bit          hold_watch = 1'b0;
  logic [4:0]  we_addr = '0;
  logic [31:0] we_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input bit wr, input logic [4:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input bit exp_err, input bit push);
    bit got;
    rsp_t e;
    got = 1'b0;
    @(posedge clock); #1;
    dbg_if.dbg_req_valid = 1'b1;
    dbg_if.dbg_req_write = wr;
    dbg_if.dbg_req_addr  = a;
    dbg_if.dbg_req_wdata = wd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (dbg_if.dbg_req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      if (push) begin
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
      end
      @(posedge clock); #1;
    end else begin
      check("req_ready_timeout", 32'd0, 32'd1);
    end
    dbg_if.dbg_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (dbg_if.dbg_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    int en0, we0, k;
    bit stable, seen;
    rsp_t got;

    dbg_if.dbg_req_valid = 1'b0;
    dbg_if.dbg_req_write = 1'b0;
    dbg_if.dbg_req_addr  = '0;
    dbg_if.dbg_req_wdata = '0;
    dbg_if.dbg_rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[0] = 32'hFFFF_FFFF;
    rf[3] = 32'hFFFF_FFFB;
    rf[5] = 32'h0000_5555;

    fork
      // Regfile model, event counters and the response monitor.
      forever begin
        @(posedge clock);
        if (rf_dbg_we) rf[rf_dbg_addr] = rf_dbg_wdata;
      end
      forever begin
        @(negedge clock);
        if (rf_dbg_en) en_cnt++;
        if (rf_dbg_we) begin
          we_cnt++;
          we_addr = rf_dbg_addr;
          we_data = rf_dbg_wdata;
        end
        if (hold_watch && !halt_req) halt_drops++;
        if (dbg_if.dbg_rsp_valid && dbg_if.dbg_rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            got = exp_q.pop_front();
            check("rsp_rdata", dbg_if.dbg_rsp_rdata, got.rdata);
            check("rsp_err", 32'(dbg_if.dbg_rsp_err), 32'(got.err));
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state and first ready after release.
    repeat (2) @(negedge clock);
    check("reset_outputs", 32'({dbg_if.dbg_req_ready, halt_req, rf_dbg_en, rf_dbg_we,
                               dbg_if.dbg_rsp_valid, halted, dbg_if.dbg_rsp_err}), 32'd0);
    #2 reset_n = 1'b1;
    #1 check("ready_before_edge", 32'(dbg_if.dbg_req_ready), 32'd0);
    @(negedge clock);
    check("first_ready", 32'(dbg_if.dbg_req_ready), 32'd1);

    // Read x3 (-5) with the pipe already empty: minimum latency path.
    pipe_empty = 1'b1;
    check("idle_halt_low", 32'(halt_req), 32'd0);
    issue(1'b0, 5'd3, 32'd0, 32'hFFFF_FFFB, 1'b0, 1'b1);
    @(negedge clock);
    check("t1_drain_halt", 32'(halt_req), 32'd1);
    check("t1_drain_halted", 32'(halted), 32'd1);
    check("t1_drain_en", 32'(rf_dbg_en), 32'd0);
    check("t1_drain_ready", 32'(dbg_if.dbg_req_ready), 32'd0);
    @(negedge clock);
    check("t1_access_en", 32'(rf_dbg_en), 32'd1);
    check("t1_access_we", 32'(rf_dbg_we), 32'd0);
    check("t1_access_addr", 32'(rf_dbg_addr), 32'd3);
    @(negedge clock);
    check("t1_rsp_valid", 32'(dbg_if.dbg_rsp_valid), 32'd1);
    @(negedge clock);
    check("t1_resume_halt", 32'(halt_req), 32'd1);
    check("t1_resume_ready", 32'(dbg_if.dbg_req_ready), 32'd0);
    @(negedge clock);
    check("t1_idle_halt", 32'(halt_req), 32'd0);
    check("t1_idle_ready", 32'(dbg_if.dbg_req_ready), 32'd1);

    // Write x1 with the pipe draining for four cycles.
    pipe_empty = 1'b0;
    en0 = en_cnt;
    we0 = we_cnt;
    issue(1'b1, 5'd1, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
    repeat (4) begin @(posedge clock); #1; end
    pipe_empty = 1'b1;
    wait_idle("t2_idle_timeout");
    check("t2_we_pulses", 32'(we_cnt - we0), 32'd1);
    check("t2_en_pulses", 32'(en_cnt - en0), 32'd1);
    check("t2_we_addr", 32'(we_addr), 32'd1);
    check("t2_we_data", we_data, 32'h1234_5678);
    check("t2_rf_x1", rf[1], 32'h1234_5678);

    // x0 is never written and always reads as zero.
    en0 = en_cnt;
    we0 = we_cnt;
    issue(1'b1, 5'd0, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
    wait_idle("t3_idle_timeout");
    check("t3_en_pulses", 32'(en_cnt - en0), 32'd1);
    check("t3_we_pulses", 32'(we_cnt - we0), 32'd0);
    check("t3_rf_x0", rf[0], 32'hFFFF_FFFF);
    issue(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    wait_idle("t3b_idle_timeout");

    // Drain timeout: pipe never empties.
    pipe_empty = 1'b0;
    en0 = en_cnt;
    issue(1'b0, 5'd5, 32'd0, 32'd0, 1'b1, 1'b1);
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      k++;
      if (dbg_if.dbg_rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("t4_timeout_seen", 32'(seen), 32'd1);
    check("t4_timeout_latency", 32'(k), 32'd17);
    wait_idle("t4_idle_timeout");
    check("t4_no_access", 32'(en_cnt - en0), 32'd0);

    // Pipe empties on the last DRAIN cycle: access wins over timeout.
    en0 = en_cnt;
    issue(1'b0, 5'd5, 32'd0, 32'h0000_5555, 1'b0, 1'b1);
    repeat (15) begin @(posedge clock); #1; end
    pipe_empty = 1'b1;
    wait_idle("t4b_idle_timeout");
    check("t4b_access", 32'(en_cnt - en0), 32'd1);

    // dbg_hold keeps the core halted across back-to-back reads.
    dbg_hold = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    hold_watch = 1'b1;
    issue(1'b0, 5'd3, 32'd0, 32'hFFFF_FFFB, 1'b0, 1'b1);
    issue(1'b0, 5'd5, 32'd0, 32'h0000_5555, 1'b0, 1'b1);
    wait_idle("t5_idle_timeout");
    repeat (2) @(negedge clock);
    hold_watch = 1'b0;
    check("t5_halt_held", 32'(halt_drops), 32'd0);
    dbg_hold = 1'b0;

    // Response held stable while the requester stalls.
    dbg_if.dbg_rsp_ready = 1'b0;
    issue(1'b0, 5'd1, 32'd0, 32'h1234_5678, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (dbg_if.dbg_rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_rsp_seen", 32'(seen), 32'd1);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (!dbg_if.dbg_rsp_valid || dbg_if.dbg_rsp_rdata !== 32'h1234_5678 || dbg_if.dbg_rsp_err !== 1'b0)
        stable = 1'b0;
    end
    check("t6_rsp_stable", 32'(stable), 32'd1);
    @(posedge clock); #1;
    dbg_if.dbg_rsp_ready = 1'b1;
    wait_idle("t6_idle_timeout");

    // Reset pulse in DRAIN: everything drops, no response, clean restart.
    pipe_empty = 1'b0;
    issue(1'b0, 5'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    #2;
    pipe_empty = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t7_reset_outputs", 32'({dbg_if.dbg_req_ready, halt_req, rf_dbg_en, rf_dbg_we,
                                  dbg_if.dbg_rsp_valid, halted, dbg_if.dbg_rsp_err}), 32'd0);
    check("t7_reset_rdata", dbg_if.dbg_rsp_rdata, 32'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    #1 check("t7_ready_before_edge", 32'(dbg_if.dbg_req_ready), 32'd0);
    @(negedge clock);
    check("t7_first_ready", 32'(dbg_if.dbg_req_ready), 32'd1);
    issue(1'b0, 5'd3, 32'd0, 32'hFFFF_FFFB, 1'b0, 1'b1);
    wait_idle("t7_idle_timeout");

    repeat (3) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_regfile_ctrl.md
DEBUG_REGFILE_CTRL -- requirements
Module: debug_regfile_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_TIMEOUT, default 16, range 1..255; the maximum number of cycles spent waiting for the pipeline to drain.
REQ-002 SHALL have clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have dbg_req_valid  input  1  debug access request present.
REQ-005 SHALL have dbg_req_ready  output  1  controller accepts a request this cycle.
REQ-006 SHALL have dbg_req_write  input  1  1 = register write, 0 = register read.
REQ-007 SHALL have dbg_req_addr  input  5  GPR index x0..x31.
REQ-008 SHALL have dbg_req_wdata  input  32  write data.
REQ-009 SHALL have dbg_rsp_valid  output  1  response present.
REQ-010 SHALL have dbg_rsp_ready  input  1  requester accepts the response.
REQ-011 SHALL have dbg_rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-012 SHALL have dbg_rsp_err  output  1  drain timeout, no access performed.
REQ-013 SHALL have dbg_hold  input  1  keep the core halted between requests.
REQ-014 SHALL have halt_req  output  1  to datapath: stop fetch, inject bubbles.
REQ-015 SHALL have pipe_empty  input  1  from datapath: no instruction in ID..WB can write the regfile.
REQ-016 SHALL have rf_dbg_en, rf_dbg_we  output  1 each  regfile debug port enable and write strobe.
REQ-017 SHALL have rf_dbg_addr  output  5  and rf_dbg_wdata  output  32  regfile debug port address and write data.
REQ-018 SHALL have rf_dbg_rdata  input  32  combinational regfile read of rf_dbg_addr.
REQ-019 SHALL have halted  output  1  high when halt_req=1 and pipe_empty=1.

Function
REQ-020 SHALL implement the FSM states IDLE, DRAIN, ACCESS, RESP and RESUME; all outputs except halted SHALL be registered or decoded from state only.
REQ-021 IDLE: dbg_req_ready=1; halt_req=dbg_hold, registered. valid&ready SHALL capture write/addr/wdata, clear the drain counter, and go to DRAIN.
REQ-022 DRAIN: halt_req=1; the 8-bit counter SHALL increment each cycle; pipe_empty=1 -> ACCESS; counter==DRAIN_TIMEOUT-1 with pipe_empty=0 -> RESP with err=1.
REQ-023 When pipe_empty and timeout occur in the same cycle, pipe_empty SHALL win and the FSM goes to ACCESS.
REQ-024 ACCESS (exactly 1 cycle): rf_dbg_en=1, rf_dbg_addr=captured addr, rf_dbg_we=write&&(addr!=0), rf_dbg_wdata=captured wdata; a read SHALL latch rf_dbg_rdata (forced 0 for x0) into dbg_rsp_rdata; next state RESP.
REQ-025 Accessing x0 SHALL never assert rf_dbg_we and SHALL return err=0.
REQ-026 RESP: dbg_rsp_valid=1, and dbg_rsp_rdata/dbg_rsp_err SHALL be held stable until dbg_rsp_ready=1, then -> RESUME.
REQ-027 RESUME (1 cycle): dbg_req_ready=0, halt_req=dbg_hold; next state IDLE.
REQ-028 rf_dbg_en SHALL be 1 only in ACCESS, and the FSM reaches ACCESS only after halt_req=1 and pipe_empty=1 were sampled.
REQ-029 dbg_req_ready SHALL be 0 in every state other than IDLE; requests are never queued.
REQ-030 Minimum latency SHALL be 3 cycles: accept edge N, DRAIN cycle N+1, ACCESS N+2, dbg_rsp_valid N+3.

Reset
REQ-031 On reset_n=0, the FSM SHALL go immediately to IDLE, clear the counter, and drive all outputs to 0 (including dbg_req_ready, halt_req, rf_dbg_en, rf_dbg_we and dbg_rsp_valid), regardless of state.
REQ-032 A reset during ACCESS SHALL suppress rf_dbg_we from the assertion onward, with no partial response.
REQ-033 The first dbg_req_ready=1 SHALL occur in the first cycle after reset_n deasserts.

Verification
REQ-034 Read x3 with pipe_empty=1 when halt_req rises and regfile x3=-5 -> ACCESS 2 cycles after accept, rsp_valid 3 cycles after accept, rdata=0xFFFFFFFB, err=0, halt_req=0 two cycles after rsp_ready.
REQ-035 Write x1=0x12345678 with pipe_empty delayed 4 cycles -> rf_dbg_we exactly one cycle with addr=1 and wdata=0x12345678, rsp err=0, rdata=0.
REQ-036 Write x0=0xDEADBEEF -> rf_dbg_en=1, rf_dbg_we=0, err=0; a read of x0 returns 0 even when rf_dbg_rdata=0xFFFFFFFF.
REQ-037 pipe_empty held 0, DRAIN_TIMEOUT=16 -> err=1 after 16 DRAIN cycles, rf_dbg_en never 1; pipe_empty rising on the 16th cycle -> normal access instead.
REQ-038 dbg_hold=1 across two back-to-back reads -> halt_req stays 1 throughout; rsp_ready held 0 for 5 cycles -> rsp data stable; reset_n pulsed during DRAIN -> all outputs 0 and IDLE.
